// File: rtl/rv32i_pkg.sv
// Shared RV32I types: CSR op/state encodings, register-file write enable, counter CSR addresses.
package rv32i_pkg;

  typedef enum logic {REG_RD = 1'b0, REG_WE = 1'b1} reg_we_e;

  typedef enum logic [1:0] {
    CSR_RW = 2'd1,
    CSR_RS = 2'd2,
    CSR_RC = 2'd3
  } csr_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } csr_state_e;

  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH = 12'hB80;
  localparam logic [11:0] CSR_CYCLE   = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH  = 12'hC80;

  // Top two address bits 2'b11 mark a read-only CSR.
  function automatic logic csr_is_ro(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running cycle counter with independently writable halves.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q;

  // A software write wins over the increment in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)       cnt_q <= '0;
    else if (we_lo_i) cnt_q <= {cnt_q[63:32], wdata_i};
    else if (we_hi_i) cnt_q <= {wdata_i, cnt_q[31:0]};
    else              cnt_q <= cnt_q + 64'd1;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr read-modify-write initiator towards the CSR file (IDLE->READ->WRITE->RESP).
// Optional cycle counter CSRs are built in when RV32I_CSR_COUNTERS_EN is defined.
module csr_access_unit
  import rv32i_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  csr_op_e           req_op,
  input  logic [CSR_AW-1:0] req_addr,
  input  logic [XLEN-1:0]   req_src,
  input  logic              req_src_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_illegal,
  output reg_we_e           csr_we,
  output logic [CSR_AW-1:0] csr_addr,
  output logic [XLEN-1:0]   csr_wdata,
  input  logic [XLEN-1:0]   csr_rdata
);

  csr_state_e        state_q, state_d;
  csr_op_e           op_q;
  logic [CSR_AW-1:0] addr_q;
  logic [XLEN-1:0]   src_q, old_q, wdata_q;
  logic              zero_q, wr_q, ill_q;

  logic [XLEN-1:0]   rd_val, new_val;
  logic              wr_req, ill, cnt_hit;

`ifdef RV32I_CSR_COUNTERS_EN
  logic [63:0] cnt;
  logic        cnt_we;

  assign cnt_hit = (addr_q == CSR_MCYCLE) || (addr_q == CSR_MCYCLEH);
  assign cnt_we  = (state_q == WRITE) && wr_q && rst_n;

  csr_counter64 u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_lo_i (cnt_we && (addr_q == CSR_MCYCLE)),
    .we_hi_i (cnt_we && (addr_q == CSR_MCYCLEH)),
    .wdata_i (wdata_q),
    .cnt_o   (cnt)
  );

  always_comb begin
    rd_val = csr_rdata;
    if ((addr_q == CSR_MCYCLE) || (addr_q == CSR_CYCLE))        rd_val = cnt[31:0];
    else if ((addr_q == CSR_MCYCLEH) || (addr_q == CSR_CYCLEH)) rd_val = cnt[63:32];
  end
`else
  assign cnt_hit = 1'b0;
  assign rd_val  = csr_rdata;
`endif

  always_comb begin
    new_val = src_q;
    case (op_q)
      CSR_RS:  new_val = rd_val | src_q;
      CSR_RC:  new_val = rd_val & ~src_q;
      default: new_val = src_q;
    endcase
  end

  // RS/RC with a zero source are pure reads and never trap on read-only CSRs.
  assign wr_req = (op_q == CSR_RW) || !zero_q;
  assign ill    = wr_req && (addr_q[CSR_AW-1 -: 2] == 2'b11);

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = READ;
      end
      READ:  state_d = WRITE;
      WRITE: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= CSR_RW;
      addr_q  <= '0;
      src_q   <= '0;
      zero_q  <= 1'b0;
      old_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        op_q   <= req_op;
        addr_q <= req_addr;
        src_q  <= req_src;
        zero_q <= req_src_zero;
      end
      if (state_q == READ) begin
        old_q   <= ill ? '0 : rd_val;
        wdata_q <= new_val;
        wr_q    <= wr_req && !ill;
        ill_q   <= ill;
      end
    end
  end

  // Gating with rst_n drops an in-flight write the moment reset is asserted.
  assign csr_we      = (state_q == WRITE && wr_q && !cnt_hit && rst_n) ? REG_WE : REG_RD;
  assign csr_addr    = addr_q;
  assign csr_wdata   = wdata_q;
  assign rsp_data    = old_q;
  assign rsp_illegal = ill_q;

endmodule
